cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control sequencer for the 16-bit processor. It steps each instruction through fetch, decode, execute, optional data-memory access and write-back. It owns the single shared memory port: instruction fetch and ld/st data access take turns, with instruction vs. data selected by `mem_sel`. It gates the opcode decoder's static control outputs so that register-file, NZ-flag and PC updates occur only in the write-back cycle.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum cycles `mem_req` may wait for `mem_ready` before faulting. 0 disables the timeout.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  1 = execute; 0 = stop at the next instruction boundary.
- `opcode`  in  5  opcode field of the instruction register.
- `dec_regwrite`  in  1  decoder register-file write enable.
- `dec_memwrite`  in  1  decoder memory write enable.
- `dec_nz`  in  1  decoder NZ-update request.
- `dec_pc_enable`  in  1  decoder PC-update request.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request.
- `mem_sel`  out  1  0 = instruction fetch, 1 = data access.
- `mem_we`  out  1  data write strobe; valid with `mem_req`.
- `ir_load`  out  1  load the instruction register from memory read data.
- `pc_enable`  out  1  commit the next PC.
- `rf_we`  out  1  register-file write.
- `nz_we`  out  1  NZ flag update.
- `fault`  out  1  sticky memory-timeout fault.
- `state`  out  3  current FSM state, for debug.
- `retired`  out  CNT_W  retired-instruction count.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6.
- IDLE → FETCH when `run`=1; otherwise stay in IDLE.
- FETCH: `mem_req`=1, `mem_sel`=0, `mem_we`=0.
  - On `mem_ready`=1: `ir_load`=1 in that same cycle (combinational), then go to DECODE.
- DECODE: one cycle, lets the decoder outputs settle. Go to EXEC.
- EXEC: one cycle for the ALU.
  - If `opcode` is 5'b00100 (ld) or 5'b00101 (st), go to MEM; otherwise go to WB.
- MEM: `mem_req`=1, `mem_sel`=1, `mem_we`=`dec_memwrite`.
  - On `mem_ready`=1, go to WB.
- WB: one cycle.
  - `rf_we`=`dec_regwrite`, `nz_we`=`dec_nz`, `pc_enable`=`dec_pc_enable`.
  - Next state: FETCH if `run`=1, else IDLE.
- Opcodes not recognised by the decoder follow the normal path; the decoder default makes them no-ops.
- `rf_we`, `nz_we`, `pc_enable` and `ir_load` are 0 in every state not listed above.
- Timeout:
  - A wait counter clears on every entry to FETCH or MEM.
  - It increments each cycle in which `mem_req`=1 and `mem_ready`=0.
  - When it reaches `MEM_TIMEOUT` (≠0), go to FAULT.
- FAULT: all strobes 0, `fault`=1. Only `reset` exits FAULT.
- `mem_ready` is ignored in IDLE, DECODE, EXEC, WB and FAULT.
- `run` is sampled only in IDLE and WB. Dropping `run` mid-instruction completes that instruction.

## Timing
- Reset values:
  - state = IDLE, wait counter = 0, `retired` = 0.
  - All outputs 0, except `state`, which shows 0 (IDLE).
- `reset` asserted in any state returns to IDLE on the next edge; any memory request in progress is abandoned.
- ALU and non-memory instructions take 4 cycles with zero-wait memory (`mem_ready` high in the first FETCH cycle).
- ld/st take 5 cycles with zero-wait memory; each memory wait cycle adds 1.
- Back-to-back: the FETCH following WB starts on the next cycle, with no bubble.
- `mem_ready` arriving in the same cycle the timeout count is reached completes normally; ready wins.
- Wait-counter width is clog2(`MEM_TIMEOUT`+1), with a minimum of 1.

## Configuration
- `CPU_SEQ_PERF_EN` defined:
  - `retired` increments by 1 on each WB cycle and wraps from 2^CNT_W−1 to 0.
  - It clears on `reset` only.
- `CPU_SEQ_PERF_EN` undefined: the counter is removed, and `retired` is tied to 0. The port list is unchanged.

## Test plan
- Reset, then `run`=1, zero-wait memory, opcode 5'b00001 (add) with `dec_regwrite`=1 → state trace 0,1,2,3,5,1. `ir_load` high in cycle 1, `rf_we` high in cycle 4 only.
- opcode 5'b00101 (st), `dec_memwrite`=1, `mem_ready` delayed 2 cycles in MEM → MEM lasts 3 cycles with `mem_sel`=1 and `mem_we`=1. WB follows, and `rf_we` equals `dec_regwrite`.
- `MEM_TIMEOUT`=3, `mem_ready` held 0 in FETCH → FAULT after 3 waiting cycles, `fault`=1 with all strobes 0. `reset` returns to IDLE with `fault`=0.
- `run` dropped during EXEC of an add → WB completes, then IDLE. Raising `run` again → FETCH on the next cycle.
- `reset` asserted in MEM with `mem_req`=1 → the next cycle shows state 0 and `mem_req`=0.
- With `CPU_SEQ_PERF_EN` and `CNT_W`=4, retire 17 instructions → `retired`=1. Without the macro, `retired` stays 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for the 16-bit CPU.
// Optional retired-instruction counter is built only when CPU_SEQ_PERF_EN is defined.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [4:0]       opcode,
    input  logic             dec_regwrite,
    input  logic             dec_memwrite,
    input  logic             dec_nz,
    input  logic             dec_pc_enable,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             mem_we,
    output logic             ir_load,
    output logic             pc_enable,
    output logic             rf_we,
    output logic             nz_we,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    // The final waiting cycle is the one in which the count would reach MEM_TIMEOUT.
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT < 1) ? 0 : MEM_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

    localparam logic [4:0] OP_LD = 5'b00100;
    localparam logic [4:0] OP_ST = 5'b00101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              mem_req_q;
    logic              mem_sel_q;
    logic              wb_q;
    logic              fault_q;

    logic              is_mem_op;
    logic              timeout_hit;

    assign is_mem_op   = (opcode == OP_LD) || (opcode == OP_ST);
    assign timeout_hit = TIMEOUT_EN && (wait_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            mem_req_q <= 1'b0;
            mem_sel_q <= 1'b0;
            wb_q      <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q   <= S_FETCH;
                        wait_q    <= '0;
                        mem_req_q <= 1'b1;
                        mem_sel_q <= 1'b0;
                    end
                end

                S_FETCH: begin
                    if (mem_ready) begin
                        state_q   <= S_DECODE;
                        mem_req_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q   <= S_FAULT;
                        mem_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end

                S_DECODE: begin
                    state_q <= S_EXEC;
                end

                S_EXEC: begin
                    if (is_mem_op) begin
                        state_q   <= S_MEM;
                        wait_q    <= '0;
                        mem_req_q <= 1'b1;
                        mem_sel_q <= 1'b1;
                    end else begin
                        state_q <= S_WB;
                        wb_q    <= 1'b1;
                    end
                end

                S_MEM: begin
                    // Ready is tested first so a response in the last allowed cycle still completes.
                    if (mem_ready) begin
                        state_q   <= S_WB;
                        mem_req_q <= 1'b0;
                        mem_sel_q <= 1'b0;
                        wb_q      <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q   <= S_FAULT;
                        mem_req_q <= 1'b0;
                        mem_sel_q <= 1'b0;
                        fault_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end

                S_WB: begin
                    wb_q <= 1'b0;
                    if (run) begin
                        state_q   <= S_FETCH;
                        wait_q    <= '0;
                        mem_req_q <= 1'b1;
                        mem_sel_q <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_FAULT: begin
                    state_q <= S_FAULT;
                end

                default: begin
                    state_q   <= S_FAULT;
                    mem_req_q <= 1'b0;
                    mem_sel_q <= 1'b0;
                    wb_q      <= 1'b0;
                    fault_q   <= 1'b1;
                end
            endcase
        end
    end

    // Decoder controls pass through only in the cycle the registered phase flags allow.
    assign mem_req   = mem_req_q;
    assign mem_sel   = mem_sel_q;
    assign mem_we    = mem_req_q & mem_sel_q & dec_memwrite;
    assign ir_load   = mem_req_q & ~mem_sel_q & mem_ready;
    assign rf_we     = wb_q & dec_regwrite;
    assign nz_we     = wb_q & dec_nz;
    assign pc_enable = wb_q & dec_pc_enable;
    assign fault     = fault_q;
    assign state     = state_q;

`ifdef CPU_SEQ_PERF_EN
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else if (state_q == S_WB) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-vector bench for cpu_sequencer: per-cycle expected outputs go into a queue
// that a negedge monitor drains and compares.
module tb_cpu_sequencer;

  localparam int CNT_W = 4;
`ifdef CPU_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_LD  = 5'b00100;
  localparam logic [4:0] OP_ST  = 5'b00101;
  localparam logic [4:0] OP_ALU = 5'b00110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             run = 1'b0;
  logic [4:0]       opcode = 5'b0;
  logic             dec_regwrite = 1'b0;
  logic             dec_memwrite = 1'b0;
  logic             dec_nz = 1'b0;
  logic             dec_pc_enable = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req;
  logic             mem_sel;
  logic             mem_we;
  logic             ir_load;
  logic             pc_enable;
  logic             rf_we;
  logic             nz_we;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  cpu_sequencer #(.MEM_TIMEOUT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .dec_regwrite(dec_regwrite), .dec_memwrite(dec_memwrite),
    .dec_nz(dec_nz), .dec_pc_enable(dec_pc_enable), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_load(ir_load),
    .pc_enable(pc_enable), .rf_we(rf_we), .nz_we(nz_we), .fault(fault),
    .state(state), .retired(retired)
  );

  // ---------------- scoreboard ----------------
  // Vector layout: {state[2:0], req, sel, we, ir_load, pc_en, rf_we, nz_we, fault, retired[3:0]}
  logic [14:0] exp_q[$];
  logic [14:0] exp_v;
  logic [14:0] act_v;
  logic [CNT_W-1:0] exp_ret = '0;
  int checks = 0;
  int passed = 0;
  int cyc_no = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {state, mem_req, mem_sel, mem_we, ir_load, pc_enable, rf_we, nz_we, fault, retired};
      checks++;
      if (act_v === exp_v) passed++;
      else $display("FAIL cycle_%0d outputs{st,req,sel,we,irl,pce,rfwe,nzwe,flt,ret}: got %b_%b_%b want %b_%b_%b",
                    cyc_no, act_v[14:12], act_v[11:4], act_v[3:0],
                    exp_v[14:12], exp_v[11:4], exp_v[3:0]);
      cyc_no++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [4:0] opc, input logic rw, input logic mw,
                           input logic nz, input logic pc);
    opcode = opc; dec_regwrite = rw; dec_memwrite = mw; dec_nz = nz; dec_pc_enable = pc;
  endtask

  // One clock cycle: drive inputs, record the outputs expected during this cycle.
  task automatic cyc(input logic r, input logic rdy, input logic rst,
                     input logic [2:0] st, input logic [7:0] strb);
    run = r; mem_ready = rdy; reset = rst;
    exp_q.push_back({st, strb, exp_ret});
    @(posedge clk); #1;
    if (rst) exp_ret = '0;
    else if (PERF && st == 3'd5) exp_ret = exp_ret + 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_ret = '0;

    // add, zero-wait: 0,1,2,3,5
    set_instr(OP_ADD, 1, 0, 0, 0);
    cyc(1, 0, 0, 3'd0, 8'b0000_0000);
    cyc(1, 1, 0, 3'd1, 8'b1001_0000);
    cyc(1, 0, 0, 3'd2, 8'b0000_0000);
    cyc(1, 0, 0, 3'd3, 8'b0000_0000);
    cyc(1, 0, 0, 3'd5, 8'b0000_0100);

    // st, MEM waits 2 cycles; ready lands on the last allowed cycle and wins
    set_instr(OP_ST, 0, 1, 0, 0);
    cyc(1, 1, 0, 3'd1, 8'b1001_0000);
    cyc(1, 0, 0, 3'd2, 8'b0000_0000);
    cyc(1, 0, 0, 3'd3, 8'b0000_0000);
    cyc(1, 0, 0, 3'd4, 8'b1110_0000);
    cyc(1, 0, 0, 3'd4, 8'b1110_0000);
    cyc(1, 1, 0, 3'd4, 8'b1110_0000);
    cyc(1, 0, 0, 3'd5, 8'b0000_0000);

    // ld with one fetch wait, regwrite + nz in WB
    set_instr(OP_LD, 1, 0, 1, 0);
    cyc(1, 0, 0, 3'd1, 8'b1000_0000);
    cyc(1, 1, 0, 3'd1, 8'b1001_0000);
    cyc(1, 0, 0, 3'd2, 8'b0000_0000);
    cyc(1, 0, 0, 3'd3, 8'b0000_0000);
    cyc(1, 1, 0, 3'd4, 8'b1100_0000);
    cyc(1, 0, 0, 3'd5, 8'b0000_0110);

    // ALU op with pc update; run dropped in EXEC -> WB then IDLE
    set_instr(OP_ALU, 0, 0, 0, 1);
    cyc(1, 1, 0, 3'd1, 8'b1001_0000);
    cyc(1, 0, 0, 3'd2, 8'b0000_0000);
    cyc(0, 0, 0, 3'd3, 8'b0000_0000);
    cyc(0, 0, 0, 3'd5, 8'b0000_1000);
    cyc(0, 1, 0, 3'd0, 8'b0000_0000);
    cyc(1, 0, 0, 3'd0, 8'b0000_0000);
    set_instr(OP_ADD, 1, 0, 0, 0);
    cyc(1, 1, 0, 3'd1, 8'b1001_0000);
    cyc(1, 0, 0, 3'd2, 8'b0000_0000);
    cyc(1, 0, 0, 3'd3, 8'b0000_0000);
    cyc(1, 0, 0, 3'd5, 8'b0000_0100);

    // reset while MEM is requesting
    set_instr(OP_LD, 1, 0, 0, 0);
    cyc(1, 1, 0, 3'd1, 8'b1001_0000);
    cyc(1, 0, 0, 3'd2, 8'b0000_0000);
    cyc(1, 0, 0, 3'd3, 8'b0000_0000);
    cyc(1, 0, 1, 3'd4, 8'b1100_0000);
    cyc(0, 0, 0, 3'd0, 8'b0000_0000);

    // timeout in FETCH: 3 waiting cycles then FAULT; decoder lines all high must stay gated
    set_instr(OP_ST, 1, 1, 1, 1);
    cyc(1, 0, 0, 3'd0, 8'b0000_0000);
    cyc(1, 0, 0, 3'd1, 8'b1000_0000);
    cyc(1, 0, 0, 3'd1, 8'b1000_0000);
    cyc(1, 0, 0, 3'd1, 8'b1000_0000);
    cyc(1, 1, 0, 3'd6, 8'b0000_0001);
    cyc(1, 1, 0, 3'd6, 8'b0000_0001);
    cyc(1, 1, 1, 3'd6, 8'b0000_0001);
    cyc(0, 0, 0, 3'd0, 8'b0000_0000);

    // 17 back-to-back adds: a 4-bit counter wraps to 1
    set_instr(OP_ADD, 1, 0, 0, 0);
    cyc(1, 0, 0, 3'd0, 8'b0000_0000);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 1, 0, 3'd1, 8'b1001_0000);
      cyc(1, 0, 0, 3'd2, 8'b0000_0000);
      cyc(1, 0, 0, 3'd3, 8'b0000_0000);
      cyc((i == 16) ? 1'b0 : 1'b1, 0, 0, 3'd5, 8'b0000_0100);
    end
    cyc(0, 0, 0, 3'd0, 8'b0000_0000);

    @(negedge clk); #1;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL final retired: got %0d want %0d", retired, exp_ret);
    end
    if (checks == 0) begin
      errors++;
      $display("FAIL no checks were performed");
    end
    if (passed != checks) errors++;
    $display("%0d/%0d checks passed", passed, checks);
    if (errors == 0) $display("PASS");
    else $display("FAIL %0d error(s)", errors);
    $finish;
  end

endmodule
